// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Round-robin front end for a single shift-add multiply engine.
// N_REQ clients each have a valid/ready request port. One granted request is
// multiplied one bit per cycle, and its product is returned on a single
// valid/ready response port tagged with the id of the client that owns it.

module mult_share_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*WIDTH-1:0]     res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
);

    // Wide enough to hold WIDTH-1, including the degenerate WIDTH=1 case
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    // Shift-add datapath; operands are zero-extended to the product width
    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] b_sh;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    // Arbitration bookkeeping
    logic [ID_W-1:0]    owner;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_found;
    logic               accept;
    logic               run_last;

    // Per-requester operand views of the packed buses
    logic [WIDTH-1:0]   a_arr [N_REQ];
    logic [WIDTH-1:0]   b_arr [N_REQ];
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    // Maps an unbounded offset from last_grant back onto a requester index
    function automatic logic [ID_W-1:0] wrap_idx(input int v);
        return ID_W'(v % N_REQ);
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    assign sel_a = a_arr[grant_idx];
    assign sel_b = b_arr[grant_idx];

    // Round-robin search: the closest valid requester after last_grant wins.
    // Scanning from the farthest offset down lets the nearest one overwrite.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid[wrap_idx(int'(last_grant) + k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(int'(last_grant) + k);
            end
        end
    end

    // req_ready is only offered to the winner, so a grant is also a handshake
    assign accept   = (state == IDLE) && grant_found;
    assign run_last = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    // State register; reset aborts any in-flight multiply
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: fixed WIDTH-cycle run, then hold the result until taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (run_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs: grant only while idle, result only while done
    always_comb begin
        req_ready = '0;
        res_valid = 1'b0;
        res_data  = '0;
        res_id    = '0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready = N_REQ'(1) << grant_idx;
                end
            end
            RUN: begin
                busy = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                res_data  = acc;
                res_id    = owner;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: capture operands on the handshake, then one shift-add step per
    // cycle with no early exit so latency never depends on the data
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            acc        <= '0;
            cnt        <= '0;
            owner      <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh       <= {{WIDTH{1'b0}}, sel_a};
                        b_sh       <= {{WIDTH{1'b0}}, sel_b};
                        acc        <= '0;
                        cnt        <= '0;
                        owner      <= grant_idx;
                        last_grant <= grant_idx;
                    end
                end
                RUN: begin
                    if (a_sh[0]) begin
                        acc <= acc + b_sh;
                    end
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh << 1;
                    cnt  <= cnt + CNT_W'(1);
                end
                default: begin
                    acc <= acc;
                end
            endcase
        end
    end

endmodule
